// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line settings, frame width, FSM state
// encodings and the clocks-per-bit derivation. Intended for reuse by uart_tx.
package uart_rx_pkg;

  localparam int unsigned DEF_CLK_FREQ = 12_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;
  localparam int unsigned DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  // Integer clocks per serial bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte sink interface: valid/ready byte handshake plus error pulses.
//   o_data       received byte, stable while o_valid=1
//   o_valid      byte available
//   i_ready      sink accepts o_data when o_valid && i_ready
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_overrun    one-cycle pulse, byte completed while previous still pending
//   o_parity_err one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// Optional feature macro: UART_RX_PARITY_EN.
interface uart_rx_if;

  logic [uart_rx_pkg::DATA_BITS-1:0] o_data;
  logic                              o_valid;
  logic                              i_ready;
  logic                              o_frame_err;
  logic                              o_overrun;
`ifdef UART_RX_PARITY_EN
  logic                              o_parity_err;
`endif

  modport master (
    input  i_ready,
    output o_data, o_valid, o_frame_err, o_overrun
`ifdef UART_RX_PARITY_EN
    , output o_parity_err
`endif
  );

  modport slave (
    output i_ready,
    input  o_data, o_valid, o_frame_err, o_overrun
`ifdef UART_RX_PARITY_EN
    , input o_parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous input pins.
//   clk_i   sampling clock
//   rst_ni  asynchronous active-low reset, both flops load RST_VAL
//   d_i     asynchronous input
//   q_o     synchronised output (2-cycle latency)
module uart_rx_sync_2ff #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises an idle-high, LSB-first 8N1 line into bytes
// delivered over a valid/ready handshake.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_rx     raw serial line, asynchronous to i_clk
//   bus      uart_rx_if.master: o_data/o_valid/i_ready, o_frame_err,
//            o_overrun, and o_parity_err when UART_RX_PARITY_EN is defined.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_rx,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_M1      = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_cpb_too_small
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;

  uart_rx_sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_c;
  logic                 done_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  // Baud counter reaches its last count: one bit period since the last sample.
  assign tick_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state, bit sampling and output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    done_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = ST_START;
          bit_d     = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        // Mid start bit; a high line here was a glitch.
        if (cnt_q == CNT_W'(HALF_M1)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        if (tick_c) begin
          par_bad_d = ^{shift_q, rx_s};
          perr_d    = ^{shift_q, rx_s};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at the stop midpoint so an immediately following start bit is seen.
        if (tick_c) begin
          if (rx_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            done_c  = !par_bad_q;
`else
            done_c  = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accept clears valid unless a new byte lands in the same cycle.
    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
    if (done_c) begin
      if (valid_q && !bus.i_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model (expected byte queue and
// expected error counts).
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned CPB = DEF_CLK_FREQ / DEF_BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned STOP_IDX = 10;
`else
  localparam int unsigned STOP_IDX = 9;
`endif
  // Pin edge -> detect cycle (2 sync flops), half bit, STOP_IDX bit periods, registered output.
  localparam int VALID_LAT = int'(2 + CPB / 2 + STOP_IDX * CPB + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  logic [7:0] got_q[$];
  int   ferr_n   = 0;
  int   ovr_n    = 0;
  int   perr_n   = 0;
  int   vhigh_n  = 0;
  int   vrise_cyc = -1;
  logic vprev    = 1'b0;

  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) got_q.push_back(bus.o_data);
    if (bus.o_valid && !vprev) vrise_cyc <= cyc;
    if (bus.o_valid) vhigh_n <= vhigh_n + 1;
    vprev  <= bus.o_valid;
    ferr_n <= ferr_n + int'(bus.o_frame_err);
    ovr_n  <= ovr_n + int'(bus.o_overrun);
`ifdef UART_RX_PARITY_EN
    perr_n <= perr_n + int'(bus.o_parity_err);
`endif
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_idle(input int n);
    rx = 1'b1;
    wait_cycles(n);
  endtask

  // Drives one frame; c0 is the cycle in which the start bit hits the pin.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input logic par_v, output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_v;
    wait_cycles(CPB);
`endif
    rx = stop_v;
    wait_cycles(CPB);
  endtask

  int c0, g0, f0, o0, v0, p0;
  logic [7:0] exp_q[$];
  int ferr_exp, perr_exp;

  initial begin
    bus.i_ready = 1'b1;
    wait_cycles(3);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_data",  int'(bus.o_data), 0);
    check("rst_ferr",  int'(bus.o_frame_err), 0);
    check("rst_ovr",   int'(bus.o_overrun), 0);
    rst_n = 1'b1;
    line_idle(10);

    // Single byte, latency and one-cycle valid.
    g0 = got_q.size(); v0 = vhigh_n;
    send_frame(8'hA5, 1'b1, ^8'hA5, c0);
    line_idle(20);
    check("t1_rise",   vrise_cyc, c0 + VALID_LAT);
    check("t1_vcycles", vhigh_n - v0, 1);
    check("t1_count",  got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t1_data", int'(got_q[g0]), 'hA5);

    // Overrun while sink stalls.
    bus.i_ready = 1'b0;
    g0 = got_q.size(); o0 = ovr_n;
    send_frame(8'h3C, 1'b1, ^8'h3C, c0);
    send_frame(8'h7E, 1'b1, ^8'h7E, c0);
    line_idle(20);
    check("t2_data",  int'(bus.o_data), 'h3C);
    check("t2_valid", int'(bus.o_valid), 1);
    check("t2_ovr",   ovr_n - o0, 1);
    bus.i_ready = 1'b1;
    wait_cycles(2);
    check("t2_drop",  int'(bus.o_valid), 0);
    check("t2_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t2_acc", int'(got_q[g0]), 'h3C);

    // Short glitch on an idle line.
    g0 = got_q.size(); f0 = ferr_n;
    rx = 1'b0;
    wait_cycles(30);
    line_idle(300);
    check("t3_count", got_q.size() - g0, 0);
    check("t3_ferr",  ferr_n - f0, 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, c0);
    line_idle(20);
    check("t3_after", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t3_data", int'(got_q[g0]), 'h5A);

    // Bad stop bit followed by a long break.
    g0 = got_q.size(); f0 = ferr_n; v0 = vhigh_n;
    send_frame(8'h55, 1'b0, ^8'h55, c0);
    rx = 1'b0;
    wait_cycles(2000);
    line_idle(50);
    check("t4_ferr",  ferr_n - f0, 1);
    check("t4_count", got_q.size() - g0, 0);
    check("t4_valid", vhigh_n - v0, 0);
    send_frame(8'h81, 1'b1, ^8'h81, c0);
    line_idle(20);
    check("t4_next",  got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t4_data", int'(got_q[g0]), 'h81);

    // Reset in the middle of a 0xFF frame.
    g0 = got_q.size(); f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(300);
    rst_n = 1'b0;
    #1;
    check("t5_rst_data",  int'(bus.o_data), 0);
    check("t5_rst_valid", int'(bus.o_valid), 0);
    wait_cycles(5);
    rst_n = 1'b1;
    line_idle(CPB * 9);
    send_frame(8'h12, 1'b1, ^8'h12, c0);
    line_idle(20);
    check("t5_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t5_data", int'(got_q[g0]), 'h12);
    check("t5_ferr", ferr_n - f0, 0);
    check("t5_ovr",  ovr_n - o0, 0);

`ifdef UART_RX_PARITY_EN
    // Parity good then bad.
    g0 = got_q.size(); p0 = perr_n;
    send_frame(8'h03, 1'b1, 1'b0, c0);
    line_idle(20);
    check("tp_good", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("tp_data", int'(got_q[g0]), 'h03);
    g0 = got_q.size();
    send_frame(8'h03, 1'b1, 1'b1, c0);
    line_idle(20);
    check("tp_perr",  perr_n - p0, 1);
    check("tp_nobyte", got_q.size() - g0, 0);
`endif

    // Randomized frames against the frame-level model.
    g0 = got_q.size(); f0 = ferr_n; o0 = ovr_n; p0 = perr_n;
    exp_q.delete();
    ferr_exp = 0;
    perr_exp = 0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      logic       stop_ok;
      logic       par_ok;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 7) != 0);
`else
      par_ok  = 1'b1;
`endif
      send_frame(b, stop_ok, par_ok ? ^b : ~^b, c0);
      if (stop_ok && par_ok) exp_q.push_back(b);
      if (!stop_ok) ferr_exp++;
      if (!par_ok) perr_exp++;
      if (!stop_ok) begin
        rx = 1'b0;
        wait_cycles(int'($urandom_range(0, 50)));
        line_idle(4 + int'($urandom_range(0, 30)));
      end else begin
        line_idle(int'($urandom_range(0, 30)));
      end
    end
    line_idle(30);
    check("rnd_count", got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > g0 + i) check($sformatf("rnd_byte%0d", i), int'(got_q[g0 + i]), int'(exp_q[i]));
    end
    check("rnd_ferr", ferr_n - f0, ferr_exp);
    check("rnd_perr", perr_n - p0, perr_exp);
    check("rnd_ovr",  ovr_n - o0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises the FTDI serial line (ftdi_rx) into bytes for on-FPGA consumers. It complements the existing pass-through/TX path, so the fabric can consume host traffic instead of only echoing it. It sits between the top-level ftdi_rx pin and a valid/ready byte sink.
- Format is 8N1 by default, LSB first, idle-high line.

Parameters:
- CLK_FREQ, 12000000, i_clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide; 104 at defaults), derived localparam. Elaboration fails if it is < 4.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_rx  input  1  raw serial line (ftdi_rx), asynchronous to i_clk.
- o_data  output  8  received byte; stable while o_valid=1.
- o_valid  output  1  byte available.
- i_ready  input  1  sink accepts o_data when o_valid&&i_ready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: byte completed while previous one still pending.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, FSM=IDLE, sync flops=1 (line idle). Reset mid-frame abandons the frame with no pulses.
- i_rx passes through a 2-flop synchroniser; the FSM sees rx_s only (2-cycle pin latency).
- FSM states and transitions:
  - IDLE: stay while rx_s=1. The cycle rx_s=0 is the detect cycle D; bit counter cleared, go to START.
  - START: at D+CLKS_PER_BIT/2 (D+52), sample rx_s. If 1 (glitch), go to IDLE with no output. If 0, go to DATA.
  - DATA: bit k (k=0..7) is sampled at D+52+(k+1)*CLKS_PER_BIT and shifted in LSB first. After bit 7, go to STOP.
  - STOP: sample at D+52+9*CLKS_PER_BIT (D+988).
    - If 1: byte is complete; go to IDLE.
    - If 0: o_frame_err pulses next cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low break therefore yields exactly one frame_err and no bytes.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reloaded on entering START. Width is clog2(CLKS_PER_BIT).
- Output handshake:
  - A completed byte raises o_valid the cycle after the stop sample (D+989).
  - o_valid holds until a cycle with i_ready=1 and o_valid=1. o_valid drops the next cycle unless a new byte completes in that same cycle.
  - Byte completes while o_valid=1 and i_ready=0: the new byte is dropped, o_data is unchanged, and o_overrun pulses 1 cycle.
  - Byte completes in the same cycle as an accept: the new byte loads, o_valid stays 1, no overrun.
- Back-to-back frames: a start bit immediately after the stop-bit midpoint is detected. Receiver returns to IDLE at the stop midpoint, not the stop end.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples even parity at D+52+9*CLKS_PER_BIT.
  - The stop sample moves to D+52+10*CLKS_PER_BIT.
  - Extra output o_parity_err (1 bit) pulses one cycle on mismatch; that byte is discarded (no o_valid).
- Undefined: no PARITY state, no o_parity_err port, 8N1 timing as above.

Decomposition:
- Shared header uart_defs.vh, also used by the future uart_tx:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default CLK_FREQ/BAUD.
  - DATA_BITS=8.
  - CLKS_PER_BIT derivation macro.
- One sub-module, sync_2ff (parameterised width, reset value 1), reusable for every asynchronous pin.

Test Plan:
- Defaults; send 0xA5 (8N1, 104 clk/bit), i_ready=1 -> o_valid exactly 1 cycle, o_data=0xA5, first high at D+989.
- Send 0x3C with i_ready=0, then 0x7E -> o_data stays 0x3C, o_valid held, one o_overrun pulse. Raise i_ready -> 0x3C accepted, o_valid=0.
- 30-clock low glitch on idle line -> no o_valid, no o_frame_err, FSM back in IDLE.
- Send 0x55 with stop bit low, then hold line low 2000 clocks -> single o_frame_err pulse, no o_valid, next good frame 0x81 received correctly.
- Assert i_rst_n=0 mid-DATA of 0xFF, release, send 0x12 -> only 0x12 delivered, no error pulses.
- UART_RX_PARITY_EN defined: 0x03 with parity 0 -> o_data=0x03; 0x03 with parity 1 -> o_parity_err pulse, no o_valid.
